// File: rtl/clk_div_gen.sv
// Multi-channel programmable clock-enable divider with glitch-free start/stop,
// boundary-aligned divisor changes and a global phase-align strobe.
module clk_div_gen #(
    parameter int CHANNELS    = 2,
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       en_i,
    input  logic [CHANNELS-1:0]       load_i,
    input  logic [CHANNELS*WIDTH-1:0] div_i,
    input  logic                      sync_i,
    output logic [CHANNELS-1:0]       en_ack_o,
    output logic [CHANNELS-1:0]       clk_o,
    output logic [CHANNELS-1:0]       tick_o
);

    localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [CHANNELS-1:0] run_q, run_d;
    logic [CHANNELS-1:0] clk_q, clk_d;
    logic [CHANNELS-1:0] tick_q, tick_d;
    logic [WIDTH-1:0]    k_q [CHANNELS];
    logic [WIDTH-1:0]    k_d [CHANNELS];
    logic [WIDTH-1:0]    d_q [CHANNELS];
    logic [WIDTH-1:0]    d_d [CHANNELS];
    logic [WIDTH-1:0]    p_q [CHANNELS];
    logic [WIDTH-1:0]    p_d [CHANNELS];
    logic [WIDTH-1:0]    nd  [CHANNELS];
    logic [CHANNELS-1:0] bnd;

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            // A same-cycle load overrides the pending divisor at a boundary
            nd[i]     = load_i[i] ? div_i[i*WIDTH +: WIDTH] : p_q[i];
            p_d[i]    = nd[i];
            run_d[i]  = run_q[i];
            k_d[i]    = k_q[i];
            d_d[i]    = d_q[i];
            bnd[i]    = !run_q[i] || (k_q[i] == d_q[i] - ONE) || sync_i;
            if (bnd[i]) begin
                k_d[i] = '0;
                if (en_i[i] && (nd[i] != '0)) begin
                    run_d[i] = 1'b1;
                    d_d[i]   = nd[i];
                end else begin
                    run_d[i] = 1'b0;
                end
            end else begin
                k_d[i] = k_q[i] + ONE;
            end
            // Outputs are computed from next state so they leave flops directly
            clk_d[i]  = run_d[i] &&
                        ({1'b0, k_d[i]} < (({1'b0, d_d[i]} + (WIDTH+1)'(1)) >> 1));
            tick_d[i] = run_d[i] && (k_d[i] == d_d[i] - ONE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q  <= '0;
            clk_q  <= '0;
            tick_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                k_q[i] <= '0;
                d_q[i] <= DEF_DIV;
                p_q[i] <= DEF_DIV;
            end
        end else begin
            run_q  <= run_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
            for (int i = 0; i < CHANNELS; i++) begin
                k_q[i] <= k_d[i];
                d_q[i] <= d_d[i];
                p_q[i] <= p_d[i];
            end
        end
    end

    assign en_ack_o = run_q;
    assign clk_o    = clk_q;
    assign tick_o   = tick_q;

endmodule

// File: tb/tb_clk_div_gen.sv
// Scoreboard bench for clk_div_gen: directed per-cycle vectors push expected
// outputs; a negedge monitor pops and compares.
module tb_clk_div_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  en_i = '0;
    logic [1:0]  load_i = '0;
    logic [15:0] div_i = '0;
    logic        sync_i = 1'b0;
    logic [1:0]  en_ack_o, clk_o, tick_o;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [5:0] exp_q[$];
    int         tag_q[$];

    clk_div_gen #(.CHANNELS(2), .WIDTH(8), .DEFAULT_DIV(2)) dut (
        .clk(clk), .rst(rst), .en_i(en_i), .load_i(load_i), .div_i(div_i),
        .sync_i(sync_i), .en_ack_o(en_ack_o), .clk_o(clk_o), .tick_o(tick_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [5:0] act,
                         input logic [5:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got ack/clk/tick=%b_%b_%b want %b_%b_%b", name,
                     act[5:4], act[3:2], act[1:0], exp[5:4], exp[3:2], exp[1:0]);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [5:0] e;
            int t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check($sformatf("step%0d", t), {en_ack_o, clk_o, tick_o}, e);
        end
    end

    task automatic step(input logic [1:0] en, input logic [1:0] ld,
                        input logic [7:0] d0, input logic [7:0] d1,
                        input logic sy, input logic [1:0] ea,
                        input logic [1:0] ec, input logic [1:0] et);
        en_i   = en;
        load_i = ld;
        div_i  = {d1, d0};
        sync_i = sy;
        @(posedge clk);
        exp_q.push_back({ea, ec, et});
        tag_q.push_back(cyc);
        cyc++;
        #1;
    endtask

    task automatic run(input logic [1:0] en, input logic [1:0] ea,
                       input logic [1:0] ec, input logic [1:0] et);
        step(en, 2'b00, 8'd0, 8'd0, 1'b0, ea, ec, et);
    endtask

    initial begin
        #2;
        check("reset_out", {en_ack_o, clk_o, tick_o}, 6'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        // D=4 start via load with en; two full periods
        step(2'b01, 2'b01, 8'd4, 8'd0, 1'b0, 2'b01, 2'b01, 2'b00);
        run(2'b01, 2'b01, 2'b01, 2'b00);
        run(2'b01, 2'b01, 2'b00, 2'b00);
        run(2'b01, 2'b01, 2'b00, 2'b01);
        run(2'b01, 2'b01, 2'b01, 2'b00);
        run(2'b01, 2'b01, 2'b01, 2'b00);
        run(2'b01, 2'b01, 2'b00, 2'b00);
        run(2'b01, 2'b01, 2'b00, 2'b01);

        // D=5 via sync+load: 1,1,1,0,0
        step(2'b01, 2'b01, 8'd5, 8'd0, 1'b1, 2'b01, 2'b01, 2'b00);
        run(2'b01, 2'b01, 2'b01, 2'b00);
        run(2'b01, 2'b01, 2'b01, 2'b00);
        run(2'b01, 2'b01, 2'b00, 2'b00);
        run(2'b01, 2'b01, 2'b00, 2'b01);
        run(2'b01, 2'b01, 2'b01, 2'b00);

        // D=1: clk constant high, tick every cycle
        step(2'b01, 2'b01, 8'd1, 8'd0, 1'b1, 2'b01, 2'b01, 2'b01);
        run(2'b01, 2'b01, 2'b01, 2'b01);
        run(2'b01, 2'b01, 2'b01, 2'b01);

        // D=4, load 6 mid-period: current period stays 4
        step(2'b01, 2'b01, 8'd4, 8'd0, 1'b1, 2'b01, 2'b01, 2'b00);
        run(2'b01, 2'b01, 2'b01, 2'b00);
        step(2'b01, 2'b01, 8'd6, 8'd0, 1'b0, 2'b01, 2'b00, 2'b00);
        run(2'b01, 2'b01, 2'b00, 2'b01);
        run(2'b01, 2'b01, 2'b01, 2'b00);
        run(2'b01, 2'b01, 2'b01, 2'b00);
        run(2'b01, 2'b01, 2'b01, 2'b00);
        run(2'b01, 2'b01, 2'b00, 2'b00);
        run(2'b01, 2'b01, 2'b00, 2'b00);
        run(2'b01, 2'b01, 2'b00, 2'b01);
        // load 3 on the tick cycle: next period is 3
        step(2'b01, 2'b01, 8'd3, 8'd0, 1'b0, 2'b01, 2'b01, 2'b00);
        run(2'b01, 2'b01, 2'b01, 2'b00);
        run(2'b01, 2'b01, 2'b00, 2'b01);

        // D=8, drop en at k=2: period completes, then stop
        step(2'b01, 2'b01, 8'd8, 8'd0, 1'b1, 2'b01, 2'b01, 2'b00);
        run(2'b01, 2'b01, 2'b01, 2'b00);
        run(2'b01, 2'b01, 2'b01, 2'b00);
        run(2'b00, 2'b01, 2'b01, 2'b00);
        run(2'b00, 2'b01, 2'b00, 2'b00);
        run(2'b00, 2'b01, 2'b00, 2'b00);
        run(2'b00, 2'b01, 2'b00, 2'b00);
        run(2'b00, 2'b01, 2'b00, 2'b01);
        run(2'b00, 2'b00, 2'b00, 2'b00);
        run(2'b00, 2'b00, 2'b00, 2'b00);

        // restart D=8, drop en then re-raise before tick: no stop
        run(2'b01, 2'b01, 2'b01, 2'b00);
        run(2'b00, 2'b01, 2'b01, 2'b00);
        run(2'b00, 2'b01, 2'b01, 2'b00);
        run(2'b00, 2'b01, 2'b01, 2'b00);
        run(2'b00, 2'b01, 2'b00, 2'b00);
        run(2'b00, 2'b01, 2'b00, 2'b00);
        run(2'b01, 2'b01, 2'b00, 2'b00);
        run(2'b01, 2'b01, 2'b00, 2'b01);
        run(2'b01, 2'b01, 2'b01, 2'b00);

        // load 0 while running: stop at period end, no restart
        step(2'b01, 2'b01, 8'd0, 8'd0, 1'b0, 2'b01, 2'b01, 2'b00);
        run(2'b01, 2'b01, 2'b01, 2'b00);
        run(2'b01, 2'b01, 2'b01, 2'b00);
        run(2'b01, 2'b01, 2'b00, 2'b00);
        run(2'b01, 2'b01, 2'b00, 2'b00);
        run(2'b01, 2'b01, 2'b00, 2'b00);
        run(2'b01, 2'b01, 2'b00, 2'b01);
        run(2'b01, 2'b00, 2'b00, 2'b00);
        run(2'b01, 2'b00, 2'b00, 2'b00);

        // ch0 D=3, ch1 D=4 at different phases, then sync
        step(2'b01, 2'b01, 8'd3, 8'd0, 1'b0, 2'b01, 2'b01, 2'b00);
        step(2'b11, 2'b10, 8'd0, 8'd4, 1'b0, 2'b11, 2'b11, 2'b00);
        run(2'b11, 2'b11, 2'b10, 2'b01);
        run(2'b11, 2'b11, 2'b01, 2'b00);
        step(2'b11, 2'b00, 8'd0, 8'd0, 1'b1, 2'b11, 2'b11, 2'b00);
        for (int s = 1; s <= 14; s++) begin
            logic [1:0] ec, et;
            ec = {((s % 4) < 2), ((s % 3) < 2)};
            et = {((s % 4) == 3), ((s % 3) == 2)};
            run(2'b11, 2'b11, ec, et);
        end

        // async reset with both channels at k=2
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        check("async_rst", {en_ack_o, clk_o, tick_o}, 6'b0);
        en_i = 2'b11;
        @(posedge clk); #1;
        check("rst_held", {en_ack_o, clk_o, tick_o}, 6'b0);
        rst = 1'b0;
        run(2'b11, 2'b11, 2'b11, 2'b00);
        run(2'b11, 2'b11, 2'b00, 2'b11);
        run(2'b11, 2'b11, 2'b11, 2'b00);
        run(2'b11, 2'b11, 2'b00, 2'b11);

        @(negedge clk); #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL sb_drain: got %0d pending want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
